// File: rtl/spi_master_cfg.sv
// spi_master_cfg: configurable SPI master with valid/ready request, all four
// CPOL/CPHA modes, runtime SCLK divider, MSB/LSB-first and one-hot enables.
//
// Ports:
//   clk, rst               system clock, async active-high reset
//   tx_data/tx_valid/tx_ready  request word and handshake
//   cpol, cpha, lsb_first  SPI mode and bit order (latched on accept)
//   clk_div                SCLK half-period = clk_div+1 clk cycles
//   cs_sel                 target slave index
//   rx_data/rx_valid       received word and one-cycle update pulse
//   busy                   transfer in progress
//   SPI_CLK/SPI_MOSI/SPI_MISO/SPI_EN  serial interface
//
// state | meaning
// IDLE  | waiting for request, SPI_CLK follows cpol input
// LEAD  | enable asserted, first bit on MOSI, one half-period
// XFER  | 2*DATA_W SCLK half-periods, shift/sample on edges
// TRAIL | SCLK parked at cpol for one half-period before release
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 1,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [CS_W-1:0]   cs_sel,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              SPI_CLK,
    output logic              SPI_MOSI,
    input  logic              SPI_MISO,
    output logic [NUM_CS-1:0] SPI_EN
);

    localparam int BW = $clog2(DATA_W);
    localparam int EW = $clog2(2 * DATA_W) + 1;
    localparam logic [BW-1:0]    MSB_POS  = BW'(DATA_W - 1);
    localparam logic [BW-1:0]    K_ONE    = BW'(1);
    localparam logic [EW-1:0]    EDGE_ONE = EW'(1);
    localparam logic [EW-1:0]    EDGE_LST = EW'(2 * DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   tx_q, rx_sh_q, rx_data_q;
    logic                cpol_q, cpha_q, lsb_q;
    logic [DIV_W-1:0]    div_cfg_q, div_q;
    logic [EW-1:0]       edge_q;
    logic [NUM_CS-1:0]   en_q, en_d;
    logic                sclk_q, mosi_q, rx_valid_q, tx_ready_q, busy_q;
    logic [BW-1:0]       k_cur, k_nxt, pos_cur, pos_nxt, pos_first;

    // Position in the word of the k-th bit on the wire.
    function automatic logic [BW-1:0] bit_pos(input logic [BW-1:0] k, input logic lsb);
        return lsb ? k : (MSB_POS - k);
    endfunction

    // Edge pairs: even edge_q = leading edge of bit k, odd = trailing edge.
    assign k_cur     = edge_q[BW:1];
    assign k_nxt     = k_cur + K_ONE;
    assign pos_cur   = bit_pos(k_cur, lsb_q);
    assign pos_nxt   = bit_pos(k_nxt, lsb_q);
    assign pos_first = bit_pos('0, lsb_first);

    // Out-of-range cs_sel decodes to no enable.
    always_comb begin
        en_d = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CS_W'(i)) en_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            div_cfg_q  <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            en_q       <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sclk_q <= cpol;
                    mosi_q <= 1'b0;
                    if (tx_valid && tx_ready_q) begin
                        state_q    <= S_LEAD;
                        tx_q       <= tx_data;
                        cpol_q     <= cpol;
                        cpha_q     <= cpha;
                        lsb_q      <= lsb_first;
                        div_cfg_q  <= clk_div;
                        div_q      <= clk_div;
                        edge_q     <= '0;
                        rx_sh_q    <= '0;
                        en_q       <= en_d;
                        mosi_q     <= tx_data[pos_first];
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (div_q == '0) begin
                        div_q   <= div_cfg_q;
                        state_q <= S_XFER;
                    end else begin
                        div_q <= div_q - DIV_ONE;
                    end
                end
                S_XFER: begin
                    if (div_q == '0) begin
                        div_q  <= div_cfg_q;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + EDGE_ONE;
                        if (!edge_q[0]) begin
                            // Leading edge: sample in mode CPHA=0, launch bit k in CPHA=1.
                            if (!cpha_q) rx_sh_q[pos_cur] <= SPI_MISO;
                            else         mosi_q <= tx_q[pos_cur];
                        end else begin
                            if (cpha_q)                   rx_sh_q[pos_cur] <= SPI_MISO;
                            else if (edge_q != EDGE_LST)  mosi_q <= tx_q[pos_nxt];
                        end
                        if (edge_q == EDGE_LST) state_q <= S_TRAIL;
                    end else begin
                        div_q <= div_q - DIV_ONE;
                    end
                end
                S_TRAIL: begin
                    sclk_q <= cpol_q;
                    if (div_q == '0) begin
                        state_q    <= S_IDLE;
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        en_q       <= '0;
                        mosi_q     <= 1'b0;
                    end else begin
                        div_q <= div_q - DIV_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign SPI_CLK  = sclk_q;
    assign SPI_MOSI = mosi_q;
    assign SPI_EN   = en_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed testbench for spi_master_cfg (DATA_W=8, NUM_CS=4).
module tb_spi_master_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic [7:0] clk_div = '0;
    logic [1:0] cs_sel = '0;
    logic [7:0] rx_data;
    logic       rx_valid, busy, SPI_CLK, SPI_MOSI, SPI_MISO;
    logic [3:0] SPI_EN;

    int n_chk = 0;
    int n_err = 0;

    // Slave model for mode 3: launches a fixed word on falling SCLK edges.
    logic       slave_en = 1'b0;
    logic       slv_miso = 1'b0;
    logic [7:0] slv_word = 8'hC3;
    int         slv_idx = 0;

    // Free-running MOSI captures on each SCLK edge while enabled.
    logic [7:0] cap_r = '0, cap_f = '0;
    int         cnt_r = 0, cnt_f = 0;

    always #5 clk = ~clk;

    assign SPI_MISO = slave_en ? slv_miso : SPI_MOSI;

    always @(negedge SPI_CLK) begin
        if (slave_en && SPI_EN[0]) begin
            slv_miso <= slv_word[7 - slv_idx];
            slv_idx  <= slv_idx + 1;
        end
    end

    always @(posedge SPI_CLK) begin
        if (|SPI_EN) begin
            cap_r <= {cap_r[6:0], SPI_MOSI};
            cnt_r <= cnt_r + 1;
        end
    end

    always @(negedge SPI_CLK) begin
        if (|SPI_EN) begin
            cap_f <= {cap_f[6:0], SPI_MOSI};
            cnt_f <= cnt_f + 1;
        end
    end

    spi_master_cfg #(.DATA_W(8), .DIV_W(8), .NUM_CS(4)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .clk_div(clk_div), .cs_sel(cs_sel),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_EN(SPI_EN)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer; inputs are changed to other values at cycle chg_at (0 = never).
    task automatic do_xfer(input logic [7:0] d, input logic pol, input logic pha,
                           input logic lsb, input logic [7:0] div, input logic [1:0] cs,
                           input int chg_at,
                           output logic [7:0] rxd, output int lat, output int en_cyc,
                           output logic [3:0] en_val, output logic sclk_done,
                           output int nr, output int nf);
        int c0r, c0f;
        tx_data = d; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div; cs_sel = cs;
        @(posedge clk); #1;
        c0r = cnt_r; c0f = cnt_f;
        tx_valid = 1'b1;
        lat = 0; en_cyc = 0; en_val = '0; rxd = '0; sclk_done = 1'b0;
        while (lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) tx_valid = 1'b0;
            if (lat == chg_at) begin
                cpol = ~pol; clk_div = div + 8'd3; tx_data = ~d;
            end
            if (|SPI_EN) begin
                en_cyc++;
                en_val = SPI_EN;
            end
            if (rx_valid) begin
                rxd = rx_data;
                sclk_done = SPI_CLK;
                break;
            end
        end
        check("xfer_timeout", 32'(lat < 2000), 32'd1);
        nr = cnt_r - c0r;
        nf = cnt_f - c0f;
        @(posedge clk); #1;
        check("rx_valid_single", 32'(rx_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] rxd, rx1, rx2;
        logic [3:0] env, en1, en2;
        logic       scd;
        int         lat, enc, nr, nf, nv, gap, nvr;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_en",       32'(SPI_EN),   32'd0);
        check("rst_mosi",     32'(SPI_MOSI), 32'd0);
        check("rst_sclk",     32'(SPI_CLK),  32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Mode 0, 0xA5, div 1, loopback
        do_xfer(8'hA5, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 0, rxd, lat, enc, env, scd, nr, nf);
        check("m0_rx",      32'(rxd),   32'hA5);
        check("m0_lat",     32'(lat),   32'd37);
        check("m0_mosi",    32'(cap_r), 32'hA5);
        check("m0_nedges",  32'(nr),    32'd8);
        check("m0_en_cyc",  32'(enc),   32'd36);
        check("m0_en_val",  32'(env),   32'b0001);

        // Mode 3, 0x3C out, slave returns 0xC3
        cpol = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("m3_idle_sclk", 32'(SPI_CLK), 32'd1);
        slave_en = 1'b1;
        do_xfer(8'h3C, 1'b1, 1'b1, 1'b0, 8'd1, 2'd0, 0, rxd, lat, enc, env, scd, nr, nf);
        slave_en = 1'b0;
        check("m3_rx",     32'(rxd),   32'hC3);
        check("m3_en_cyc", 32'(enc),   32'd36);
        check("m3_mosi",   32'(cap_r), 32'h3C);
        check("m3_lat",    32'(lat),   32'd37);
        check("m3_sclk_hi_done", 32'(SPI_CLK), 32'd1);

        // Mode 1, LSB first, 0x01, div 0 (SCLK = clk/2)
        do_xfer(8'h01, 1'b0, 1'b1, 1'b1, 8'd0, 2'd0, 0, rxd, lat, enc, env, scd, nr, nf);
        check("m1_mosi",   32'(cap_f), 32'h80);
        check("m1_nedges", 32'(nf),    32'd8);
        check("m1_rx",     32'(rxd),   32'h01);
        check("m1_lat",    32'(lat),   32'd19);

        // cs_sel 2, div 2
        do_xfer(8'h5A, 1'b0, 1'b0, 1'b0, 8'd2, 2'd2, 0, rxd, lat, enc, env, scd, nr, nf);
        check("cs2_en_val", 32'(env), 32'b0100);
        check("cs2_rx",     32'(rxd), 32'h5A);
        check("cs2_lat",    32'(lat), 32'd55);
        check("cs2_en_cyc", 32'(enc), 32'd54);

        // Back-to-back: cs 3 then cs 2, tx_valid held high
        tx_data = 8'h81; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0; cs_sel = 2'd3;
        tx_valid = 1'b1;
        nv = 0; gap = 0; en1 = '0; en2 = '0; rx1 = '0; rx2 = '0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rx_valid) begin
                nv++;
                if (nv == 1) begin
                    rx1 = rx_data;
                    cs_sel = 2'd2;
                    tx_data = 8'h7E;
                end else begin
                    rx2 = rx_data;
                end
            end
            if (nv >= 1 && busy) tx_valid = 1'b0;
            if (nv == 0 && SPI_EN != 4'b0000) en1 = SPI_EN;
            if (nv == 1 && SPI_EN == 4'b0000) gap++;
            if (nv == 1 && SPI_EN != 4'b0000) en2 = SPI_EN;
            if (nv == 2) break;
        end
        tx_valid = 1'b0;
        check("b2b_pulses", 32'(nv),  32'd2);
        check("b2b_en1",    32'(en1), 32'b1000);
        check("b2b_en2",    32'(en2), 32'b0100);
        check("b2b_gap",    32'(gap), 32'd1);
        check("b2b_rx1",    32'(rx1), 32'h81);
        check("b2b_rx2",    32'(rx2), 32'h7E);
        repeat (2) @(posedge clk);
        #1;

        // Config stability: cpol, clk_div, tx_data changed at cycle 5
        do_xfer(8'h96, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 5, rxd, lat, enc, env, scd, nr, nf);
        check("cfg_rx",        32'(rxd),     32'h96);
        check("cfg_lat",       32'(lat),     32'd37);
        check("cfg_mosi",      32'(cap_r),   32'h96);
        check("cfg_nedges",    32'(nr),      32'd8);
        check("cfg_sclk_done", 32'(scd),     32'd0);
        check("cfg_sclk_idle", 32'(SPI_CLK), 32'd1);

        // Reset in the middle of XFER (after bit 3)
        tx_data = 8'hF0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1; cs_sel = 2'd0;
        @(posedge clk); #1;
        tx_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) tx_valid = 1'b0;
        end
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",     32'(busy),     32'd0);
        check("mid_rst_ready",    32'(tx_ready), 32'd1);
        check("mid_rst_en",       32'(SPI_EN),   32'd0);
        check("mid_rst_mosi",     32'(SPI_MOSI), 32'd0);
        check("mid_rst_sclk",     32'(SPI_CLK),  32'd0);
        check("mid_rst_rx_data",  32'(rx_data),  32'd0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        nvr = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (rx_valid) nvr++;
        end
        check("mid_no_rx_valid", 32'(nvr), 32'd0);
        do_xfer(8'h3C, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 0, rxd, lat, enc, env, scd, nr, nf);
        check("post_rst_rx",  32'(rxd), 32'h3C);
        check("post_rst_lat", 32'(lat), 32'd37);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
